wb_merge_queue: RTL and testbench
=================================

Name: wb_merge_queue

Overview:
- Writeback-stage merge unit between the execute/memory pipes and the register-file write port.
- Each cycle it accepts an ALU result and a load result, retires at most one register write, and queues deferred ALU writes in a small FIFO.
- When the queue is full, it applies backpressure to the ALU pipe.
- It also exposes a lookup port so hazard logic can forward still-queued values.

Parameters:
XLEN, 32, data width
REG_W, 5, register index width
DEPTH, 2, deferred-ALU queue entries (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present
alu_rd  in  REG_W  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  queue can accept an ALU result this cycle
mem_valid  in  1  load result present (never stalled)
mem_rd  in  REG_W  load destination
mem_data  in  XLEN  load result
wb_en  out  1  register-file write enable (registered)
wb_rd  out  REG_W  write index (registered)
wb_data  out  XLEN  write data (registered)
collision  out  1  registered; high in the wb cycle of a load that displaced an ALU result
q_count  out  clog2(DEPTH+1)  queued entries
chk_rs  in  REG_W  forwarding lookup index
chk_hit  out  1  queued entry matches chk_rs (combinational)
chk_data  out  XLEN  data of the youngest matching queued entry

Behaviour:
- Reset: synchronous, active-high. It clears count, head/tail pointers, wb_en, wb_rd, wb_data and collision to 0. After reset, alu_ready=1 and chk_hit=0.
- Results with rd==0 are discarded:
  - alu_valid with alu_rd==0 is accepted (if alu_ready) but never enqueued or written.
  - mem_valid with mem_rd==0 writes nothing and frees the port for the queue.
- ALU acceptance: accept = alu_valid & alu_ready.
  - alu_ready = (count < DEPTH). It depends on registered count only, not on same-cycle dequeue.
  - If alu_valid & !alu_ready, the producer holds its inputs. Nothing is taken.
- Retire priority, one write per cycle (effective = valid & rd!=0):
  1. Effective mem: write mem.
  2. Else queue non-empty: write head, dequeue.
  3. Else accepted effective ALU: write ALU directly (bypasses empty queue).
  4. Else wb_en=0.
- Enqueue rule: an accepted effective ALU result is enqueued if it was not retired directly. This covers both a queue that is non-empty and a cycle where mem wins.
- Ordering is strict arrival order. ALU never overtakes queued entries.
- On a same-cycle tie, mem is written first and ALU later. The ALU instruction is defined as younger, so its value persists.
- Latency: 1 cycle. The write selected in cycle N appears on wb_* in cycle N+1.
- wb_rd and wb_data hold their last value when wb_en=0.
- collision: set in N+1 iff in cycle N effective mem and effective accepted ALU were both present.
- count update: count_next = count + enq - deq. Simultaneous enqueue and dequeue when full is impossible, because alu_ready=0.
- Pointers wrap modulo DEPTH.
- Forwarding lookup:
  - Searches only registered queue contents (not same-cycle inputs), youngest to oldest.
  - chk_rs==0 gives chk_hit=0.
  - chk_data=0 when there is no hit.
- Reset mid-operation discards all queued entries; no pending write retires.

Test Plan:
1. Single ALU write: alu_valid=1, rd=5, data=0x11 for one cycle, queue empty → next cycle wb_en=1, rd=5, data=0x11; collision=0, q_count=0.
2. Tie: same cycle mem(rd=3, 0xAA) and alu(rd=4, 0xBB) → cycle+1: write r3=0xAA with collision=1, q_count=1. Cycle+2: write r4=0xBB, collision=0, q_count=0.
3. Backpressure, DEPTH=2: mem valid three consecutive cycles with alu valid each cycle (rd 6, 7, 8) → after two cycles alu_ready=0 and rd8 is held. After mem stops, writes retire in order 6, 7, then 8 once accepted, each one cycle apart.
4. Same rd ordering: tie mem(rd=9, 1) and alu(rd=9, 2) → r9 written 1, then 2. The final register value is 2.
5. x0 handling: alu rd=0 and mem rd=0 together → no wb_en, collision=0. Then with one queued entry plus mem rd=0 → the queued entry retires that cycle.
6. Forwarding and reset: queue holds rd=12 as 0x5 (older) and 0x6 (younger). chk_rs=12 gives hit=1, data=0x6; chk_rs=0 gives hit=0. Assert rst one cycle → q_count=0, wb_en=0, alu_ready=1, and no queued write ever appears.

Source files
------------

// File: rtl/wb_merge_queue_if.sv
// Writeback merge bus: ALU/load producer side, register-file write side,
// queue occupancy and the hazard-forwarding lookup port.
interface wb_merge_queue_if #(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             alu_valid;
   logic [REG_W-1:0] alu_rd;
   logic [XLEN-1:0]  alu_data;
   logic             alu_ready;
   logic             mem_valid;
   logic [REG_W-1:0] mem_rd;
   logic [XLEN-1:0]  mem_data;
   logic             wb_en;
   logic [REG_W-1:0] wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             collision;
   logic [CW-1:0]    q_count;
   logic [REG_W-1:0] chk_rs;
   logic             chk_hit;
   logic [XLEN-1:0]  chk_data;

   modport master (
      output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs,
      input  alu_ready, wb_en, wb_rd, wb_data, collision, q_count, chk_hit, chk_data
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, chk_rs,
      output alu_ready, wb_en, wb_rd, wb_data, collision, q_count, chk_hit, chk_data
   );
endinterface

// File: rtl/wb_merge_queue.sv
// Writeback merge unit: retires one register write per cycle, giving loads
// priority and parking displaced ALU results in a small in-order FIFO that
// can be searched for forwarding.
module wb_merge_queue #(
   parameter int XLEN  = 32,
   parameter int REG_W = 5,
   parameter int DEPTH = 2
) (
   input logic            clk,
   input logic            rst,
   wb_merge_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [REG_W-1:0] qRd   [DEPTH];
   logic [XLEN-1:0]  qData [DEPTH];
   logic [PW-1:0]    headPtr;
   logic [PW-1:0]    tailPtr;
   logic [CW-1:0]    count;

   logic             wbEnQ;
   logic [REG_W-1:0] wbRdQ;
   logic [XLEN-1:0]  wbDataQ;
   logic             collisionQ;

   logic             aluReady;
   logic             aluEff;
   logic             memEff;
   logic             enq;
   logic             deq;
   logic             selEn;
   logic [REG_W-1:0] selRd;
   logic [XLEN-1:0]  selData;
   logic             fwdHit;
   logic [XLEN-1:0]  fwdData;

   function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign aluReady = (count < CW'(DEPTH));
   assign aluEff   = bus.alu_valid && aluReady && (bus.alu_rd != '0);
   assign memEff   = bus.mem_valid && (bus.mem_rd != '0);

   // Retire selection: load first, then queue head, then direct ALU bypass.
   always_comb begin
      enq     = 1'b0;
      deq     = 1'b0;
      selEn   = 1'b0;
      selRd   = bus.mem_rd;
      selData = bus.mem_data;
      if (memEff) begin
         selEn = 1'b1;
         enq   = aluEff;
      end else if (count != '0) begin
         selEn   = 1'b1;
         deq     = 1'b1;
         selRd   = qRd[headPtr];
         selData = qData[headPtr];
         enq     = aluEff;
      end else if (aluEff) begin
         selEn   = 1'b1;
         selRd   = bus.alu_rd;
         selData = bus.alu_data;
      end
   end

   // Queue storage; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (enq) begin
         qRd[tailPtr]   <= bus.alu_rd;
         qData[tailPtr] <= bus.alu_data;
      end
   end

   // Queue pointers, occupancy and registered writeback outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
         wbEnQ      <= 1'b0;
         wbRdQ      <= '0;
         wbDataQ    <= '0;
         collisionQ <= 1'b0;
      end else begin
         if (enq) tailPtr <= bumpPtr(tailPtr);
         if (deq) headPtr <= bumpPtr(headPtr);
         count      <= count + CW'(enq) - CW'(deq);
         wbEnQ      <= selEn;
         collisionQ <= memEff && aluEff;
         if (selEn) begin
            wbRdQ   <= selRd;
            wbDataQ <= selData;
         end
      end
   end

   // Forwarding search oldest-to-youngest so the youngest match wins.
   always_comb begin
      int unsigned slot;
      slot    = 0;
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot = (32'(headPtr) + i) % DEPTH;
         if ((i < 32'(count)) && (bus.chk_rs != '0) && (qRd[slot[PW-1:0]] == bus.chk_rs)) begin
            fwdHit  = 1'b1;
            fwdData = qData[slot[PW-1:0]];
         end
      end
   end

   assign bus.alu_ready = aluReady;
   assign bus.wb_en     = wbEnQ;
   assign bus.wb_rd     = wbRdQ;
   assign bus.wb_data   = wbDataQ;
   assign bus.collision = collisionQ;
   assign bus.q_count   = count;
   assign bus.chk_hit   = fwdHit;
   assign bus.chk_data  = fwdData;
endmodule

// File: tb/tb_wb_merge_queue.sv
// Bench for wb_merge_queue: directed scenarios followed by a randomized run,
// all checked against a queue-based model of the retire rules.
module tb_wb_merge_queue;
   localparam int XLEN  = 32;
   localparam int REG_W = 5;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_merge_queue_if #(.XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();
   wb_merge_queue #(.XLEN(XLEN), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   ent_t             mq[$];
   logic             mWbEn;
   logic             mColl;
   logic [REG_W-1:0] mWbRd;
   logic [XLEN-1:0]  mWbData;
   logic             lastAcc;
   int               nCmp = 0;
   int               nErr = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive, check combinational outputs, advance model, check registered outputs.
   task automatic cyc(input logic r, input logic av, input logic [REG_W-1:0] ard,
                      input logic [XLEN-1:0] ad, input logic mv, input logic [REG_W-1:0] mrd,
                      input logic [XLEN-1:0] md, input logic [REG_W-1:0] rs);
      logic             ready, aluEff, memEff, fHit;
      logic [XLEN-1:0]  fData;
      ent_t             e;
      rst = r;
      bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
      bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
      bus.chk_rs = rs;
      #1;
      ready = (mq.size() < DEPTH);
      if (!r) begin
         fHit = 1'b0;
         fData = '0;
         foreach (mq[i]) if (rs != 0 && mq[i].rd == rs) begin fHit = 1'b1; fData = mq[i].data; end
         chk("alu_ready", bus.alu_ready, ready);
         chk("q_count", bus.q_count, mq.size());
         chk("chk_hit", bus.chk_hit, fHit);
         chk("chk_data", bus.chk_data, fData);
      end
      lastAcc = av && ready && !r;
      if (r) begin
         mq.delete();
         mWbEn = 1'b0; mWbRd = '0; mWbData = '0; mColl = 1'b0;
      end else begin
         aluEff = lastAcc && (ard != 0);
         memEff = mv && (mrd != 0);
         mColl  = memEff && aluEff;
         mWbEn  = 1'b1;
         if (memEff) begin
            mWbRd = mrd; mWbData = md;
            if (aluEff) mq.push_back({ard, ad});
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mWbRd = e.rd; mWbData = e.data;
            if (aluEff) mq.push_back({ard, ad});
         end else if (aluEff) begin
            mWbRd = ard; mWbData = ad;
         end else begin
            mWbEn = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("wb_en", bus.wb_en, mWbEn);
      chk("wb_rd", bus.wb_rd, mWbRd);
      chk("wb_data", bus.wb_data, mWbData);
      chk("collision", bus.collision, mColl);
   endtask

   initial begin
      logic             pav, mv, r;
      logic [REG_W-1:0] prd, mrd;
      logic [XLEN-1:0]  pdata, mdata;

      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      // Single ALU write bypasses the empty queue
      cyc(0, 1, 5, 'h11, 0, 0, 0, 0);
      chk("t1_wb_data", bus.wb_data, 'h11);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Tie: load wins, ALU follows next cycle
      cyc(0, 1, 4, 'hBB, 1, 3, 'hAA, 4);
      chk("t2_collision", bus.collision, 1);
      chk("t2_rd_first", bus.wb_rd, 3);
      cyc(0, 0, 0, 0, 0, 0, 0, 4);
      chk("t2_rd_second", bus.wb_rd, 4);

      // Backpressure: rd8 is held until the queue drains
      cyc(0, 1, 6, 'h60, 1, 20, 'h200, 0);
      cyc(0, 1, 7, 'h70, 1, 21, 'h210, 7);
      cyc(0, 1, 8, 'h80, 1, 22, 'h220, 6);
      chk("t3_not_ready", bus.alu_ready, 0);
      cyc(0, 1, 8, 'h80, 0, 0, 0, 0);
      cyc(0, 1, 8, 'h80, 0, 0, 0, 8);
      cyc(0, 0, 0, 0, 0, 0, 0, 8);
      chk("t3_last_rd", bus.wb_rd, 8);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // Same destination: younger ALU value lands last
      cyc(0, 1, 9, 2, 1, 9, 1, 9);
      cyc(0, 0, 0, 0, 0, 0, 0, 9);
      chk("t4_final", bus.wb_data, 2);

      // x0 results write nothing; mem to x0 frees the port for the queue
      cyc(0, 1, 0, 'h1, 1, 0, 'h2, 0);
      cyc(0, 1, 2, 'h22, 1, 1, 'h11, 2);
      cyc(0, 0, 0, 0, 1, 0, 'h33, 2);
      chk("t5_rd", bus.wb_rd, 2);

      // Forwarding picks the youngest entry, then reset discards the queue
      cyc(0, 1, 12, 5, 1, 1, 'hA1, 12);
      cyc(0, 1, 12, 6, 1, 1, 'hA2, 12);
      bus.chk_rs = 12;
      #1;
      chk("t6_hit", bus.chk_hit, 1);
      chk("t6_data", bus.chk_data, 6);
      bus.chk_rs = 0;
      #1;
      chk("t6_hit_x0", bus.chk_hit, 0);
      cyc(1, 1, 13, 7, 1, 14, 8, 12);
      chk("t6_rst_count", bus.q_count, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 12);
      cyc(0, 0, 0, 0, 0, 0, 0, 12);

      // Randomized traffic; the ALU producer holds its item until accepted
      pav = 1'b0; prd = '0; pdata = '0; lastAcc = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!pav || lastAcc) begin
            pav   = ($urandom_range(0, 99) < 60);
            prd   = REG_W'($urandom_range(0, 7));
            pdata = $urandom;
         end
         mv    = ($urandom_range(0, 99) < 45);
         mrd   = REG_W'($urandom_range(0, 7));
         mdata = $urandom;
         r     = ($urandom_range(0, 99) < 2);
         cyc(r, pav, prd, pdata, mv, mrd, mdata, REG_W'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
